stack_port_sequencer: RTL

- Owns the stack pointer (SP) and sequences multi-word stack operations over the single 16-bit data-memory port: PUSH, POP, CALL, RET, INT and RTI.
- Arbitrates that port between the sequencer and ordinary MEM-stage loads and stores.
- Stalls the pipeline until a multi-word operation completes.
- Sits at the MEM stage, between the pipeline register and the data memory.

---
 rtl/stack_port_sequencer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/stack_port_sequencer.sv
// stack_port_sequencer
// ---------------------------------------------------------------------------
// Owns the stack pointer and sequences multi-word stack operations (PUSH,
// POP, CALL, RET, INT, RTI) over the single data-memory port at the MEM
// stage. It also arbitrates that port against ordinary MEM-stage loads and
// stores, and stalls the pipeline while a multi-word operation is in flight.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   op_valid, op_code   : stack-operation request (1 PUSH .. 6 RTI, 0/7 none)
//   push_data           : PUSH operand
//   pc_in, flags_in     : return PC (CALL/INT) and flags (INT)
//   mem_req, mem_we_in,
//   mem_addr_in,
//   mem_wdata_in        : ordinary load/store request from the MEM stage
//   mem_grant           : ordinary request is on the memory port this cycle
//   mem_re, mem_we,
//   mem_addr, mem_wdata : data-memory port
//   mem_rdata           : asynchronous read data (same cycle as mem_re)
//   stall               : freeze IF..MEM
//   pop_data, pop_load  : POP result and strobe
//   pc_out, pc_load     : popped PC and strobe (RET/RTI)
//   flags_out,
//   flags_load          : popped flags and strobe (RTI)
//   sp_out              : current stack pointer
//   busy                : an access sequence is in progress
// ---------------------------------------------------------------------------
module stack_port_sequencer #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 11,
  parameter int                PC_W    = 32,
  parameter int                FLAG_W  = 3,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] push_data,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              mem_req,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  output logic              mem_grant,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_load,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              flags_load,
  output logic [ADDR_W-1:0] sp_out,
  output logic              busy
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_INT  = 3'd5;
  localparam logic [2:0] OP_RTI  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam logic [ADDR_W-1:0] SP_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // W0..W2 are the first, second and third memory word of an operation.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_W0   = 2'd1,
    S_W1   = 2'd2,
    S_W2   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   push_q, push_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [DATA_W-1:0]   lo_q, lo_d;          // PC low word read by RET/RTI
  logic [FLAG_W-1:0]   flags_rd_q, flags_rd_d; // flags word read by RTI

  logic [1:0]          step;
  logic                last_step;
  logic [ADDR_W-1:0]   sp_inc;

  // Index of the final word: one less than the word count of the operation.
  function automatic logic [1:0] last_idx(input logic [2:0] op);
    logic [1:0] idx;
    case (op)
      OP_PUSH, OP_POP: idx = 2'd0;
      OP_CALL, OP_RET: idx = 2'd1;
      OP_INT,  OP_RTI: idx = 2'd2;
      default:         idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_push_op(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  // Word written at a given step: pushes go high PC word first so that the
  // pop side reads them back low word first.
  function automatic logic [DATA_W-1:0] push_word(
    input logic [2:0]        op,
    input logic [1:0]        stp,
    input logic [DATA_W-1:0] pdata,
    input logic [PC_W-1:0]   pc,
    input logic [FLAG_W-1:0] flg
  );
    logic [DATA_W-1:0] w;
    case (op)
      OP_PUSH: w = pdata;
      OP_CALL, OP_INT: begin
        case (stp)
          2'd0:    w = pc[PC_W-1:DATA_W];
          2'd1:    w = pc[DATA_W-1:0];
          default: w = {{(DATA_W-FLAG_W){1'b0}}, flg};
        endcase
      end
      default: w = {DATA_W{1'b0}};
    endcase
    return w;
  endfunction

  // State register and operand/holding registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sp_q       <= SP_INIT;
      op_q       <= OP_NONE;
      push_q     <= {DATA_W{1'b0}};
      pc_q       <= {PC_W{1'b0}};
      flags_q    <= {FLAG_W{1'b0}};
      lo_q       <= {DATA_W{1'b0}};
      flags_rd_q <= {FLAG_W{1'b0}};
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      op_q       <= op_d;
      push_q     <= push_d;
      pc_q       <= pc_d;
      flags_q    <= flags_d;
      lo_q       <= lo_d;
      flags_rd_q <= flags_rd_d;
    end
  end

  // Next-state, SP arithmetic, memory-port mux and completion strobes.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    op_d       = op_q;
    push_d     = push_q;
    pc_d       = pc_q;
    flags_d    = flags_q;
    lo_d       = lo_q;
    flags_rd_d = flags_rd_q;

    mem_grant  = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    stall      = 1'b0;
    pop_data   = {DATA_W{1'b0}};
    pop_load   = 1'b0;
    pc_out     = {PC_W{1'b0}};
    pc_load    = 1'b0;
    flags_out  = {FLAG_W{1'b0}};
    flags_load = 1'b0;

    step       = 2'd0;
    last_step  = 1'b0;
    sp_inc     = sp_q + SP_ONE;

    case (state_q)
      S_IDLE: begin
        if (op_valid && (op_code != OP_NONE) && (op_code != OP_RSVD)) begin
          // Accept cycle: latch operands, hold the pipeline, leave the port idle.
          stall   = 1'b1;
          state_d = S_W0;
          op_d    = op_code;
          push_d  = push_data;
          pc_d    = pc_in;
          flags_d = flags_in;
        end else begin
          mem_grant = mem_req;
          mem_re    = mem_req & ~mem_we_in;
          mem_we    = mem_req & mem_we_in;
          mem_addr  = mem_addr_in;
          mem_wdata = mem_wdata_in;
        end
      end
      S_W0, S_W1, S_W2: begin
        step      = state_q - 2'd1;
        last_step = (step >= last_idx(op_q));
        stall     = ~last_step;
        if (last_step) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_t'(state_q + 2'd1);
        end

        if (is_push_op(op_q)) begin
          mem_we    = 1'b1;
          mem_addr  = sp_q;
          mem_wdata = push_word(op_q, step, push_q, pc_q, flags_q);
          sp_d      = sp_q - SP_ONE;
        end else begin
          // Pre-increment: the read address is the SP value taken at the edge.
          mem_re   = 1'b1;
          mem_addr = sp_inc;
          sp_d     = sp_inc;
          case (op_q)
            OP_POP: begin
              pop_data = mem_rdata;
              pop_load = 1'b1;
            end
            OP_RET: begin
              if (step == 2'd0) begin
                lo_d = mem_rdata;
              end else begin
                pc_out  = {mem_rdata, lo_q};
                pc_load = 1'b1;
              end
            end
            OP_RTI: begin
              case (step)
                2'd0: flags_rd_d = mem_rdata[FLAG_W-1:0];
                2'd1: lo_d       = mem_rdata;
                default: begin
                  pc_out     = {mem_rdata, lo_q};
                  pc_load    = 1'b1;
                  flags_out  = flags_rd_q;
                  flags_load = 1'b1;
                end
              endcase
            end
            default: begin
              pop_load = 1'b0;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sp_out = sp_q;
  assign busy   = (state_q != S_IDLE);

endmodule
